code_fetch: RTL

- Read-side master for port B of the code RAM (dp_ram); the JTAG loader writes port A.
- Streams sequential opcodes from the RAM into a small prefetch FIFO.
- Presents them to the core over a valid/ready handshake.
- Supports redirect (jump) and stop/restart under core_control.running.

---
 rtl/code_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/code_fetch.sv
// Sequential opcode prefetcher: reads code RAM port B into a small FIFO and hands opcodes to the core.
// Optional CODE_FETCH_STATS_EN adds push/stall counters.
`timescale 1ns/1ps
module code_fetch #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              running,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_write,
    input  logic [DATA_W-1:0] ram_read,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_data,
    output logic [ADDR_W-1:0] op_addr,
    input  logic              op_ready,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] fetch_pc
`ifdef CODE_FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_stalls
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t              r_state, w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_inflight_addr;
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]      r_count;

    logic                w_stop, w_jump, w_flush, w_issue, w_push, w_pop;
    logic [PTR_W+1:0]    w_occupancy;

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (running)  w_next_state = S_FETCH;
            S_FETCH: if (!running) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Occupancy counts the inflight word so a full FIFO never loses a RAM response.
    assign w_occupancy = {1'b0, r_count} + {{(PTR_W + 1){1'b0}}, r_inflight};
    assign w_stop      = (r_state == S_FETCH) && !running;
    assign w_jump      = (r_state == S_FETCH) && running && jump_valid;
    assign w_flush     = w_stop || w_jump;
    assign w_issue     = (r_state == S_FETCH) && running && !jump_valid &&
                         (w_occupancy < (PTR_W + 2)'(FIFO_DEPTH));
    assign w_push      = r_inflight && !w_flush;
    assign w_pop       = op_valid && op_ready;

    assign op_valid  = (r_count != '0);
    assign op_data   = r_fifo_data[r_rd_ptr];
    assign op_addr   = r_fifo_addr[r_rd_ptr];
    assign ram_addr  = r_pc;
    assign fetch_pc  = r_pc;
    assign ram_we    = 1'b0;
    assign ram_write = '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_pc            <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            if (w_issue) r_inflight_addr <= r_pc;
            if (w_stop)       r_pc <= '0;
            else if (w_jump)  r_pc <= jump_addr;
            else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage is reset because op_data/op_addr must read 0 straight out of reset; it is only a few flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_read;
            r_fifo_addr[r_wr_ptr] <= r_inflight_addr;
        end
    end

`ifdef CODE_FETCH_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_fetched <= '0;
            stat_stalls  <= '0;
        end else if (w_stop) begin
            stat_fetched <= '0;
            stat_stalls  <= '0;
        end else begin
            if (w_push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
            if ((r_state == S_FETCH) && !op_valid && (stat_stalls != '1))
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule
